// File: rtl/on_off_transmitter_pkg.sv
// on_off_transmitter_pkg: link-level NoC parameters and the flit format
//   VC_NUM          number of virtual channels on a link
//   FLIT_VC_W       width of the vc_id field carried in every flit
//   ON_OFF_LATENCY  flag round trip the downstream buffers reserve slack for
//   flit_t          {vc_id, payload}
package on_off_transmitter_pkg;
  localparam int VC_NUM = 4;
  localparam int FLIT_VC_W = $clog2(VC_NUM);
  localparam int ON_OFF_LATENCY = 2;
  localparam int PAYLOAD_W = 16;
  typedef struct packed {
    logic [FLIT_VC_W-1:0] vc_id;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;
endpackage

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: one-hot round-robin grant over N requesters
//   clk, rst_n  clock, asynchronous active-low reset
//   i_req       request vector
//   o_grant     one-hot grant, zero when nothing requests
// The priority pointer moves to one past the winner and holds when idle.
module round_robin_arbiter #(
  parameter int N = 4,
  localparam int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant
);
  logic [PW-1:0] r_rr;
  logic [PW-1:0] w_idx;
  logic          w_found;
  int            w_k;
  always_comb begin
    w_found = 1'b0;
    w_idx = '0;
    w_k = 0;
    for (int i = 0; i < N; i++) begin
      w_k = (int'(r_rr) + i) % N;
      if (!w_found && i_req[w_k]) begin
        w_found = 1'b1;
        w_idx = PW'(w_k);
      end
    end
    o_grant = w_found ? (N'(1) << w_idx) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rr <= '0;
    else if (w_found) r_rr <= (w_idx == PW'(N - 1)) ? '0 : w_idx + 1'b1;
endmodule

// File: rtl/on_off_transmitter.sv
// on_off_transmitter: upstream end of an on/off flow-controlled link
//   clk, rst_n  clock, asynchronous active-low reset
//   data_i      flit from switch traversal, routed to slot data_i.vc_id
//   valid_i     data_i valid; taken when ready_o[data_i.vc_id] is set
//   ready_o     per-VC acceptance: slot empty or being launched this cycle
//   on_off_i    per-VC downstream flag, 1 = may send (used unregistered)
//   data_o      registered link flit, holds when idle
//   valid_o     registered link valid
module on_off_transmitter
  import on_off_transmitter_pkg::*;
#(
  parameter int VC_NUM = on_off_transmitter_pkg::VC_NUM,
  parameter int FLIT_VC_W = $clog2(VC_NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  flit_t             data_i,
  input  logic              valid_i,
  output logic [VC_NUM-1:0] ready_o,
  input  logic [VC_NUM-1:0] on_off_i,
  output flit_t             data_o,
  output logic              valid_o
);
  logic [VC_NUM-1:0] r_full;
  flit_t             r_slot [VC_NUM];
  logic [VC_NUM-1:0] w_grant;
  logic [VC_NUM-1:0] w_wr;
  logic [FLIT_VC_W-1:0] w_vc;
  flit_t             w_flit;
  assign w_vc = FLIT_VC_W'(data_i.vc_id);
  round_robin_arbiter #(.N(VC_NUM)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (r_full & on_off_i),
    .o_grant(w_grant)
  );
  // grant never looks at valid_i/data_i, so ready_o -> valid_i has no loop
  assign ready_o = ~r_full | w_grant;
  always_comb begin
    w_wr = '0;
    w_flit = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      w_wr[v] = valid_i && int'(w_vc) == v && ready_o[v];
      if (w_grant[v]) w_flit = r_slot[v];
    end
  end
  // a write wins over a grant so a VC can stream one flit per cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_full <= '0;
      valid_o <= 1'b0;
      data_o <= '0;
    end else begin
      for (int v = 0; v < VC_NUM; v++)
        if (w_wr[v]) r_full[v] <= 1'b1;
        else if (w_grant[v]) r_full[v] <= 1'b0;
      valid_o <= |w_grant;
      if (|w_grant) data_o <= w_flit;
    end
  always_ff @(posedge clk)
    for (int v = 0; v < VC_NUM; v++)
      if (w_wr[v]) r_slot[v] <= data_i;
endmodule
